// File: rtl/handshake_constant_pkg.sv
// Shared definitions for the handshake constant sequencer: the index-width
// helper and the depth limit.
package handshake_constant_pkg;

    localparam int MAX_DEPTH = 256;

    // A one-entry table still needs a 1-bit index so the counter is never zero-width.
    function automatic int idx_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/handshake_constant_seq_slot.sv
// One-slot output register with valid/ready handshake on both sides.
// The slot accepts a new word whenever it is empty or is being drained in the same cycle.
module handshake_constant_seq_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  w_load;

    assign o_ready = !r_full || i_ready;
    assign w_load  = i_valid && o_ready;

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so
    // the load/drain decision never sees a half-updated slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
        end else if (i_ready) begin
            // Drain without reload: data and last keep their values.
            r_full <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_full;

endmodule

// File: rtl/handshake_constant_seq.sv
// Streams a parameter table of constants, one word per accepted control token.
// Optional macro HANDSHAKE_CONSTANT_SEQ_RESTART_EN adds a synchronous restart input.
module handshake_constant_seq
    import handshake_constant_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] TABLE      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef HANDSHAKE_CONSTANT_SEQ_RESTART_EN
    input  logic                  restart,
`endif
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int               IDX_W    = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("handshake_constant_seq: DEPTH out of range");
    end

    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_sel;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_restart;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_table [DEPTH];

`ifdef HANDSHAKE_CONSTANT_SEQ_RESTART_EN
    assign w_restart = restart;
`else
    assign w_restart = 1'b0;
`endif

    assign w_accept   = ctrl_valid && ctrl_ready;
    // A token coinciding with restart consumes entry 0.
    assign w_idx_sel  = w_restart ? '0 : r_idx;
    assign w_idx_next = (w_idx_sel == LAST_IDX) ? '0 : w_idx_sel + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_idx_next;
        end else if (w_restart) begin
            r_idx <= '0;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        assign w_table[k] = TABLE[k*DATA_WIDTH +: DATA_WIDTH];
    end

    if (DEPTH == 1) begin : g_single
        assign w_word = w_table[0];
    end else begin : g_multi
        assign w_word = w_table[w_idx_sel];
    end

    assign w_last = (w_idx_sel == LAST_IDX);

    handshake_constant_seq_slot #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_word),
        .i_last (w_last),
        .i_valid(ctrl_valid),
        .o_ready(ctrl_ready),
        .o_data (outs),
        .o_last (outs_last),
        .o_valid(outs_valid),
        .i_ready(outs_ready)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Scoreboard bench for handshake_constant_seq: a 3-entry instance and a 1-entry instance.
// Restart stimulus is included when HANDSHAKE_CONSTANT_SEQ_RESTART_EN is defined.
module tb_handshake_constant_seq;

    localparam int                   DW     = 17;
    localparam int                   DEPTH  = 3;
    localparam logic [DEPTH*DW-1:0]  TBL    = {17'h0000C, 17'h0000B, 17'h0000A};
    localparam logic [DW-1:0]        SINGLE = 17'h080E7;
    localparam logic [DW-1:0]        EXP_TBL [DEPTH] = '{17'h0000A, 17'h0000B, 17'h0000C};

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          restart = 1'b0;
    logic          ctrl_valid = 1'b0, ctrl_ready;
    logic [DW-1:0] outs;
    logic          outs_valid, outs_ready = 1'b0, outs_last;
    logic          ctrl_valid1 = 1'b0, ctrl_ready1;
    logic [DW-1:0] outs1;
    logic          outs_valid1, outs_ready1 = 1'b0, outs_last1;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_del1 = 0;
    int   m_idx = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TABLE(TBL)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef HANDSHAKE_CONSTANT_SEQ_RESTART_EN
        .restart   (restart),
`endif
        .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready),
        .outs      (outs),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready),
        .outs_last (outs_last)
    );

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(1), .TABLE(SINGLE)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
`ifdef HANDSHAKE_CONSTANT_SEQ_RESTART_EN
        .restart   (1'b0),
`endif
        .ctrl_valid(ctrl_valid1),
        .ctrl_ready(ctrl_ready1),
        .outs      (outs1),
        .outs_valid(outs_valid1),
        .outs_ready(outs_ready1),
        .outs_last (outs_last1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        ctrl_valid  = 1'b0;
        outs_ready  = 1'b0;
        restart     = 1'b0;
        ctrl_valid1 = 1'b0;
        outs_ready1 = 1'b0;
        q.delete();
        m_idx = 0;
        tick();
        rst = 1'b1;
    endtask

    // Expected-word producer: one entry per accepted token.
    initial forever begin
        int   used;
        exp_t e;
        @(negedge clk);
        if (rst && ctrl_valid && ctrl_ready) begin
            used = m_idx;
            if (restart) used = 0;
            e.data = EXP_TBL[used];
            e.last = (used == DEPTH - 1);
            q.push_back(e);
            m_idx = (used + 1) % DEPTH;
        end else if (rst && restart) begin
            m_idx = 0;
        end
    end

    // Monitor: every delivered word must match the oldest expected entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && outs_valid && outs_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h, expected no word", outs);
            end else begin
                e = q.pop_front();
                check("word", {47'd0, outs}, {47'd0, e.data});
                check("last", {63'd0, outs_last}, {63'd0, e.last});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst && outs_valid1 && outs_ready1) begin
            n_del1++;
            check("single_word", {47'd0, outs1}, {47'd0, SINGLE});
            check("single_last", {63'd0, outs_last1}, 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        // Reset state with a token offered: must not be taken.
        ctrl_valid = 1'b1;
        #1;
        check("rst_outs", {47'd0, outs}, 64'd0);
        check("rst_valid", {63'd0, outs_valid}, 64'd0);
        check("rst_last", {63'd0, outs_last}, 64'd0);
        check("rst_ready", {63'd0, ctrl_ready}, 64'd1);
        tick();
        tick();
        ctrl_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Full throughput, seven tokens.
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("thru_valid", {63'd0, outs_valid}, 64'd1);
        end
        ctrl_valid = 1'b0;
        tick();
        tick();

        // Backpressure on the first word.
        do_reset();
        ctrl_valid = 1'b1;
        outs_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", {47'd0, outs}, 64'h0A);
            check("bp_ready", {63'd0, ctrl_ready}, 64'd0);
            tick();
        end
        outs_ready = 1'b1;
        tick();
        check("bp_next", {47'd0, outs}, 64'h0B);
        check("bp_nogap", {63'd0, outs_valid}, 64'd1);
        ctrl_valid = 1'b0;
        tick();

        // Asynchronous reset while 0x0B is pending.
        do_reset();
        ctrl_valid = 1'b1;
        tick();
        outs_ready = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        outs_ready = 1'b0;
        check("pend_b", {47'd0, outs}, 64'h0B);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", {63'd0, outs_valid}, 64'd0);
        check("arst_outs", {47'd0, outs}, 64'd0);
        check("arst_last", {63'd0, outs_last}, 64'd0);
        check("arst_ready", {63'd0, ctrl_ready}, 64'd1);
        q.delete();
        m_idx = 0;
        tick();
        rst = 1'b1;
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        tick();
        check("after_rst", {47'd0, outs}, 64'h0A);
        ctrl_valid = 1'b0;
        tick();

`ifdef HANDSHAKE_CONSTANT_SEQ_RESTART_EN
        do_reset();
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_word", {47'd0, outs}, 64'h0A);
        tick();
        check("restart_then", {47'd0, outs}, 64'h0B);
        ctrl_valid = 1'b0;
        tick();
`endif

        // Single-entry table at full throughput.
        ctrl_valid1 = 1'b1;
        outs_ready1 = 1'b1;
        d0 = n_del1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("single_valid", {63'd0, outs_valid1}, 64'd1);
        end
        check("single_count", 64'(n_del1 - d0), 64'd7);

        // Random handshakes on both instances.
        for (int i = 0; i < 3000; i++) begin
            ctrl_valid  = 1'($urandom_range(0, 1));
            outs_ready  = 1'($urandom_range(0, 1));
            ctrl_valid1 = 1'($urandom_range(0, 1));
            outs_ready1 = 1'($urandom_range(0, 1));
            tick();
        end

        ctrl_valid  = 1'b0;
        ctrl_valid1 = 1'b0;
        outs_ready  = 1'b1;
        outs_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("drained", 64'(q.size()), 64'd0);
        check("idle_valid", {63'd0, outs_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
